wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Writeback stage that sits directly upstream of the 16x16 register file and drives its two write ports.
- Accepts retiring ops from the memory stage: ALU single result, ALU dual result (mul hi/lo, div quotient/remainder) or load.
- Waits for load data and issues well-formed one-cycle write pulses.
- Exports load-pending, bypass and retire-count information for decode and hazard logic.

Parameters:
DW, 16, data width of register file entries
AW, 4, register address width (16 registers)
CW, 16, width of retire counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  memory stage presents an op
in_ready  out  1  stage can accept an op this cycle
wb_sel  in  2  00 none, 01 ALU single, 10 load, 11 ALU dual
rd_a  in  AW  primary destination
rd_b  in  AW  secondary destination (dual only)
res_a  in  DW  primary result
res_b  in  DW  secondary result
mem_rvalid  in  1  load data valid pulse
mem_rdata  in  DW  load data
w_enable1  out  1  register file write port 1 enable
w_enable2  out  1  register file write port 2 enable
addr1  out  AW  port 1 address
addr2  out  AW  port 2 address
d1writeback  out  DW  port 1 data
d2writeback  out  DW  port 2 data
ld_pending  out  1  a load is awaiting data
ld_rd  out  AW  destination of the pending load (0 when none)
retire_cnt  out  CW  ops retired since reset, wraps
stray_rvalid  out  1  sticky: mem_rvalid seen with no load pending

Behaviour:
- State machine has two states.
  - IDLE: in_ready=1.
  - WAIT_LD: in_ready=0.
  - While rst=1, in_ready is forced to 0.
- Reset (synchronous) values:
  - State IDLE.
  - All write outputs, addresses and data 0.
  - ld_pending=0, ld_rd=0, retire_cnt=0, stray_rvalid=0.
- Accept occurs when in_valid && in_ready. In all cases below, "next cycle" means a pulse lasting exactly one cycle, registered, with latency 1 from accept.
  - wb_sel=00: no write; retire_cnt+1 next cycle.
  - wb_sel=01: next cycle w_enable1=1, addr1=rd_a, d1writeback=res_a; w_enable2=0.
  - wb_sel=11, rd_a!=rd_b: next cycle both ports pulse with (rd_a, res_a) on port 1 and (rd_b, res_b) on port 2.
  - wb_sel=11, rd_a==rd_b: port 1 only, with (rd_b, res_b). Secondary wins and the same-address dual write is never presented.
  - wb_sel=10: go to WAIT_LD, latching rd_a into ld_rd; ld_pending=1 from the next cycle.
- WAIT_LD:
  - On mem_rvalid, next cycle port 1 pulses with (ld_rd, mem_rdata).
  - In the same cycle as that pulse, state returns to IDLE, ld_pending=0 and ld_rd=0.
  - The earliest mem_rvalid that counts is the cycle after accept.
  - No back-to-back accept is possible on a load; in_ready returns to 1 the cycle after mem_rvalid.
- Port rules:
  - w_enable2 is never asserted without w_enable1.
  - Whenever an enable is 0, its address and data are 0.
- retire_cnt increments, wrapping at 2^CW, in the cycle the op's write pulse is driven.
  - For wb_sel=00, this is the cycle after accept.
  - Loads count once, on their data write.
- mem_rvalid in IDLE (including a late response after reset mid-load) is ignored for writes and sets stray_rvalid. stray_rvalid is cleared only by rst.
- Reset mid-load abandons the load: no write and no retire.
- Register 0 is an ordinary writable register; the stage does not filter any address.
- Decode bypasses from w_enable*/addr*/d*writeback. The register file commits at the end of the pulse cycle, so this stage adds no extra bypass logic.

Decomposition:
- Shared package holds:
  - WB_NONE/WB_ALU/WB_LOAD/WB_DUAL 2-bit constants.
  - The state enum (IDLE, WAIT_LD).
  - DW/AW defaults.
- A sub-module wb_port_merge is natural: it is the combinational dual-write collision and zeroing logic feeding the output registers.
- The rest, the FSM, counter and output flops, stays flat.

Test Plan:
- Reset, then ALU op rd_a=3, res_a=16'h1234 accepted at cycle t -> cycle t+1 w_enable1=1, addr1=3, d1writeback=16'h1234, w_enable2=0, retire_cnt=1; at t+2 all write outputs 0.
- Dual op rd_a=5/16'hAAAA, rd_b=6/16'h5555 -> one cycle with both enables; port 1=(5,AAAA), port 2=(6,5555). Repeat with rd_b=5 -> only w_enable1, addr1=5, d1writeback=16'h5555.
- Load rd_a=9, mem_rvalid 4 cycles later with 16'hBEEF -> ld_pending=1 and ld_rd=9 while waiting; in_ready=0 and in_valid ignored; write (9,BEEF) the cycle after rvalid; in_ready=1 that cycle.
- Reset asserted during WAIT_LD, then mem_rvalid arrives -> no write pulse; stray_rvalid=1; retire_cnt=0.
- Back-to-back 2^16+2 ALU ops with in_valid held high -> one write per cycle; retire_cnt wraps to 2.
- wb_sel=00 accepted -> no enable asserted; retire_cnt increments by 1.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage: op selectors, FSM
// states and default widths of the register-file interface.
package wb_stage_pkg;

   localparam int WB_DW = 16;
   localparam int WB_AW = 4;
   localparam int WB_CW = 16;

   localparam logic [1:0] WB_NONE = 2'b00;
   localparam logic [1:0] WB_ALU  = 2'b01;
   localparam logic [1:0] WB_LOAD = 2'b10;
   localparam logic [1:0] WB_DUAL = 2'b11;

   typedef enum logic {
      IDLE    = 1'b0,
      WAIT_LD = 1'b1
   } wb_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// Bundle between memory stage, load-data return, register-file write ports
// and hazard/decode status. The slave side is the writeback stage itself.
interface wb_stage_if
   import wb_stage_pkg::*;
#(
   parameter int DW = WB_DW,
   parameter int AW = WB_AW,
   parameter int CW = WB_CW
) ();

   logic          in_valid;
   logic          in_ready;
   logic [1:0]    wb_sel;
   logic [AW-1:0] rd_a;
   logic [AW-1:0] rd_b;
   logic [DW-1:0] res_a;
   logic [DW-1:0] res_b;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;
   logic          w_enable1;
   logic          w_enable2;
   logic [AW-1:0] addr1;
   logic [AW-1:0] addr2;
   logic [DW-1:0] d1writeback;
   logic [DW-1:0] d2writeback;
   logic          ld_pending;
   logic [AW-1:0] ld_rd;
   logic [CW-1:0] retire_cnt;
   logic          stray_rvalid;

   modport master (
      output in_valid, wb_sel, rd_a, rd_b, res_a, res_b, mem_rvalid, mem_rdata,
      input  in_ready, w_enable1, w_enable2, addr1, addr2, d1writeback,
             d2writeback, ld_pending, ld_rd, retire_cnt, stray_rvalid
   );

   modport slave (
      input  in_valid, wb_sel, rd_a, rd_b, res_a, res_b, mem_rvalid, mem_rdata,
      output in_ready, w_enable1, w_enable2, addr1, addr2, d1writeback,
             d2writeback, ld_pending, ld_rd, retire_cnt, stray_rvalid
   );

endinterface

// File: rtl/wb_port_merge.sv
// Combinational write-port shaping: resolves same-address dual writes in
// favour of the secondary result and zeroes every idle port.
module wb_port_merge #(
   parameter int DW = 16,
   parameter int AW = 4
) (
   input  logic          i_req1,
   input  logic          i_req2,
   input  logic [AW-1:0] i_addr1,
   input  logic [AW-1:0] i_addr2,
   input  logic [DW-1:0] i_data1,
   input  logic [DW-1:0] i_data2,
   output logic          o_en1,
   output logic          o_en2,
   output logic [AW-1:0] o_addr1,
   output logic [AW-1:0] o_addr2,
   output logic [DW-1:0] o_data1,
   output logic [DW-1:0] o_data2
);

   logic w_collide;

   assign w_collide = i_req1 && i_req2 && (i_addr1 == i_addr2);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      o_en1   = 1'b0;
      o_en2   = 1'b0;
      o_addr1 = '0;
      o_addr2 = '0;
      o_data1 = '0;
      o_data2 = '0;
      if (i_req1) begin
         o_en1 = 1'b1;
         if (w_collide) begin
            o_addr1 = i_addr2;
            o_data1 = i_data2;
         end else begin
            o_addr1 = i_addr1;
            o_data1 = i_data1;
         end
      end
      // Port 2 only ever rides alongside port 1, and never to the same register.
      if (i_req1 && i_req2 && !w_collide) begin
         o_en2   = 1'b1;
         o_addr2 = i_addr2;
         o_data2 = i_data2;
      end
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts retiring ops, waits for load data and drives
// one-cycle registered write pulses into the register file.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int DW = WB_DW,
   parameter int AW = WB_AW,
   parameter int CW = WB_CW
) (
   input  logic     clk,
   input  logic     rst,
   wb_stage_if.slave bus
);

   wb_state_t     r_state;
   wb_state_t     w_next_state;

   logic          w_accept;
   logic          w_ld_done;
   logic          w_retire;
   logic          w_req1;
   logic          w_req2;
   logic [AW-1:0] w_addr1;
   logic [DW-1:0] w_data1;

   logic          w_m_en1;
   logic          w_m_en2;
   logic [AW-1:0] w_m_addr1;
   logic [AW-1:0] w_m_addr2;
   logic [DW-1:0] w_m_data1;
   logic [DW-1:0] w_m_data2;

   logic          r_en1;
   logic          r_en2;
   logic [AW-1:0] r_addr1;
   logic [AW-1:0] r_addr2;
   logic [DW-1:0] r_data1;
   logic [DW-1:0] r_data2;
   logic [AW-1:0] r_ld_rd;
   logic [CW-1:0] r_retire_cnt;
   logic          r_stray;

   assign bus.in_ready = (r_state == IDLE) && !rst;
   assign w_accept     = bus.in_valid && bus.in_ready;
   assign w_ld_done    = (r_state == WAIT_LD) && bus.mem_rvalid;

   // Load completion and a new accept are exclusive by state, so they share port 1.
   assign w_req1   = w_ld_done || (w_accept && (bus.wb_sel == WB_ALU || bus.wb_sel == WB_DUAL));
   assign w_req2   = w_accept && (bus.wb_sel == WB_DUAL);
   assign w_addr1  = w_ld_done ? r_ld_rd : bus.rd_a;
   assign w_data1  = w_ld_done ? bus.mem_rdata : bus.res_a;
   assign w_retire = w_ld_done || (w_accept && (bus.wb_sel != WB_LOAD));

   wb_port_merge #(.DW(DW), .AW(AW)) u_merge (
      .i_req1  (w_req1),
      .i_req2  (w_req2),
      .i_addr1 (w_addr1),
      .i_addr2 (bus.rd_b),
      .i_data1 (w_data1),
      .i_data2 (bus.res_b),
      .o_en1   (w_m_en1),
      .o_en2   (w_m_en2),
      .o_addr1 (w_m_addr1),
      .o_addr2 (w_m_addr2),
      .o_data1 (w_m_data1),
      .o_data2 (w_m_data2)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept && bus.wb_sel == WB_LOAD) w_next_state = WAIT_LD;
         WAIT_LD: if (bus.mem_rvalid)                    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_en1        <= 1'b0;
         r_en2        <= 1'b0;
         r_addr1      <= '0;
         r_addr2      <= '0;
         r_data1      <= '0;
         r_data2      <= '0;
         r_ld_rd      <= '0;
         r_retire_cnt <= '0;
         r_stray      <= 1'b0;
      end else begin
         r_en1   <= w_m_en1;
         r_en2   <= w_m_en2;
         r_addr1 <= w_m_addr1;
         r_addr2 <= w_m_addr2;
         r_data1 <= w_m_data1;
         r_data2 <= w_m_data2;
         if (w_retire) r_retire_cnt <= r_retire_cnt + CW'(1);
         if (w_accept && bus.wb_sel == WB_LOAD) r_ld_rd <= bus.rd_a;
         else if (w_ld_done)                    r_ld_rd <= '0;
         // A response with no load outstanding is flagged, never written.
         if (r_state == IDLE && bus.mem_rvalid) r_stray <= 1'b1;
      end
   end

   assign bus.w_enable1    = r_en1;
   assign bus.w_enable2    = r_en2;
   assign bus.addr1        = r_addr1;
   assign bus.addr2        = r_addr2;
   assign bus.d1writeback  = r_data1;
   assign bus.d2writeback  = r_data2;
   assign bus.ld_pending   = (r_state == WAIT_LD);
   assign bus.ld_rd        = r_ld_rd;
   assign bus.retire_cnt   = r_retire_cnt;
   assign bus.stray_rvalid = r_stray;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected write-port values are queued as each
// cycle's stimulus is driven and compared after the following clock edge.
module tb_wb_stage;
   import wb_stage_pkg::*;

   typedef struct packed {
      logic        en1;
      logic        en2;
      logic [3:0]  a1;
      logic [3:0]  a2;
      logic [15:0] d1;
      logic [15:0] d2;
   } wr_t;

   localparam wr_t NO_WR = '0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   wr_t  sb_q[$];

   wb_stage_if #(.DW(16), .AW(4), .CW(16)) bus ();

   wb_stage #(.DW(16), .AW(4), .CW(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic wr_t wr1(input logic [3:0] a, input logic [15:0] d);
      wr_t w = '0;
      w.en1 = 1'b1; w.a1 = a; w.d1 = d;
      return w;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Queue this cycle's expectation, clock once, then pop and compare the ports.
   task automatic cyc(input string tag, input wr_t exp);
      wr_t obs;
      wr_t e;
      sb_q.push_back(exp);
      @(posedge clk);
      #1;
      obs = {bus.w_enable1, bus.w_enable2, bus.addr1, bus.addr2,
             bus.d1writeback, bus.d2writeback};
      e = sb_q.pop_front();
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] sel,
                        input logic [3:0] ra, input logic [15:0] xa,
                        input logic [3:0] rb, input logic [15:0] xb);
      bus.in_valid = v;
      bus.wb_sel   = sel;
      bus.rd_a     = ra;
      bus.res_a    = xa;
      bus.rd_b     = rb;
      bus.res_b    = xb;
   endtask

   initial begin
      wr_t w;
      drive(1'b0, WB_NONE, 4'd0, 16'h0, 4'd0, 16'h0);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 16'h0;

      // Reset state
      cyc("rst_ports0", NO_WR);
      cyc("rst_ports1", NO_WR);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_ld_pending", bus.ld_pending, 0);
      check("rst_ld_rd", bus.ld_rd, 0);
      check("rst_retire", bus.retire_cnt, 0);
      check("rst_stray", bus.stray_rvalid, 0);
      rst = 1'b0;
      #1;
      check("idle_in_ready", bus.in_ready, 1);

      // ALU single
      drive(1'b1, WB_ALU, 4'd3, 16'h1234, 4'd0, 16'h0);
      cyc("alu_pulse", wr1(4'd3, 16'h1234));
      check("alu_retire", bus.retire_cnt, 1);
      drive(1'b0, WB_NONE, 4'd0, 16'h0, 4'd0, 16'h0);
      cyc("alu_end", NO_WR);

      // Dual, distinct addresses
      drive(1'b1, WB_DUAL, 4'd5, 16'hAAAA, 4'd6, 16'h5555);
      w = wr1(4'd5, 16'hAAAA);
      w.en2 = 1'b1; w.a2 = 4'd6; w.d2 = 16'h5555;
      cyc("dual_pulse", w);
      check("dual_retire", bus.retire_cnt, 2);

      // Dual, same address: secondary wins on port 1 only
      drive(1'b1, WB_DUAL, 4'd5, 16'hAAAA, 4'd5, 16'h5555);
      cyc("dual_same_pulse", wr1(4'd5, 16'h5555));
      check("dual_same_retire", bus.retire_cnt, 3);
      drive(1'b0, WB_NONE, 4'd0, 16'h0, 4'd0, 16'h0);
      cyc("dual_end", NO_WR);

      // Load rd=9, data returns four cycles after accept
      drive(1'b1, WB_LOAD, 4'd9, 16'h0, 4'd0, 16'h0);
      cyc("ld_accept", NO_WR);
      drive(1'b1, WB_ALU, 4'd2, 16'h7777, 4'd0, 16'h0);
      for (int i = 0; i < 3; i++) begin
         check("ld_pending", bus.ld_pending, 1);
         check("ld_rd", bus.ld_rd, 9);
         check("ld_in_ready", bus.in_ready, 0);
         cyc("ld_wait", NO_WR);
      end
      check("ld_retire_wait", bus.retire_cnt, 3);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 16'hBEEF;
      cyc("ld_pulse", wr1(4'd9, 16'hBEEF));
      check("ld_done_in_ready", bus.in_ready, 1);
      check("ld_done_pending", bus.ld_pending, 0);
      check("ld_done_rd", bus.ld_rd, 0);
      check("ld_retire", bus.retire_cnt, 4);
      bus.mem_rvalid = 1'b0;
      drive(1'b0, WB_NONE, 4'd0, 16'h0, 4'd0, 16'h0);
      cyc("ld_end", NO_WR);
      check("ld_no_stray", bus.stray_rvalid, 0);

      // wb_sel=00 retires without writing
      drive(1'b1, WB_NONE, 4'd4, 16'h4444, 4'd0, 16'h0);
      cyc("none_pulse", NO_WR);
      check("none_retire", bus.retire_cnt, 5);
      drive(1'b0, WB_NONE, 4'd0, 16'h0, 4'd0, 16'h0);

      // Reset mid-load, then a late response
      drive(1'b1, WB_LOAD, 4'd7, 16'h0, 4'd0, 16'h0);
      cyc("rl_accept", NO_WR);
      drive(1'b0, WB_NONE, 4'd0, 16'h0, 4'd0, 16'h0);
      check("rl_pending", bus.ld_pending, 1);
      rst = 1'b1;
      cyc("rl_reset", NO_WR);
      check("rl_pending_clr", bus.ld_pending, 0);
      rst = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 16'hDEAD;
      cyc("rl_late_rvalid", NO_WR);
      check("rl_stray", bus.stray_rvalid, 1);
      check("rl_retire", bus.retire_cnt, 0);
      bus.mem_rvalid = 1'b0;
      cyc("rl_quiet", NO_WR);
      check("rl_stray_sticky", bus.stray_rvalid, 1);

      // Register 0 is writable
      drive(1'b1, WB_ALU, 4'd0, 16'hFFFF, 4'd0, 16'h0);
      cyc("r0_pulse", wr1(4'd0, 16'hFFFF));
      drive(1'b0, WB_NONE, 4'd0, 16'h0, 4'd0, 16'h0);

      // Back-to-back ALU stream across retire_cnt wrap
      rst = 1'b1;
      cyc("wrap_reset", NO_WR);
      check("wrap_stray_clr", bus.stray_rvalid, 0);
      rst = 1'b0;
      for (int i = 0; i < 65538; i++) begin
         logic [31:0] iv;
         iv = i;
         drive(1'b1, WB_ALU, iv[3:0], iv[15:0] ^ 16'h5A5A, 4'd0, 16'h0);
         cyc("stream_pulse", wr1(iv[3:0], iv[15:0] ^ 16'h5A5A));
      end
      drive(1'b0, WB_NONE, 4'd0, 16'h0, 4'd0, 16'h0);
      check("wrap_retire", bus.retire_cnt, 2);
      cyc("stream_end", NO_WR);
      check("sb_drained", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
